// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared definitions for the NTT datapath: default ring parameters used by
// the twiddle generator, butterfly and controller, the twiddle-generator FSM
// state encoding, and a width-parametrised bit-reversal helper.
// ---------------------------------------------------------------------------
package ntt_pkg;

   // Default ring: N = 16, Q = 257 (fits in 9 bits), psi = 2, psi^-1 = 129
   localparam int DEF_LOG_N   = 4;
   localparam int DEF_QW      = 9;
   localparam int DEF_Q       = 257;
   localparam int DEF_PSI     = 2;
   localparam int DEF_PSI_INV = 129;

   typedef enum logic [1:0] {
      S_WRITE = 2'd0,
      S_MUL   = 2'd1,
      S_READY = 2'd2
   } tbl_state_e;

   // Reverse the low w bits of v; bits at and above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) begin
            r = {r[30:0], v[i]};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// ---------------------------------------------------------------------------
// mod_mul_serial
// Bit-serial interleaved modular multiplier: result = a * b_const mod Q.
// Scans b_const MSB-first, one bit per cycle, for QW cycles. Every step only
// doubles, adds and conditionally subtracts Q, so all intermediates stay below
// 2Q and fit in QW+1 bits. Operand a must already be reduced (a < Q).
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   start     : load a and begin a multiplication (ignored while busy)
//   a         : variable operand, sampled on start
//   b_const   : constant operand, scanned MSB-first
//   busy      : multiplication in progress
//   done      : the current cycle performs the last step; result is valid now
//   result    : fully reduced product, valid while done=1
// ---------------------------------------------------------------------------
module mod_mul_serial #(
   parameter int QW = 9,
   parameter int Q  = 257
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [QW-1:0] a,
   input  logic [QW-1:0] b_const,
   output logic          busy,
   output logic          done,
   output logic [QW-1:0] result
);

   localparam int            CW      = (QW > 1) ? $clog2(QW) : 1;
   localparam logic [QW:0]   Q_X     = (QW+1)'(Q);
   localparam logic [CW-1:0] CNT_TOP = CW'(QW - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
   localparam logic [CW-1:0] CNT_ZRO = CW'(1'b0);

   logic [QW-1:0] a_q, a_d;
   logic [QW-1:0] r_q, r_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   logic [QW:0]   dbl_s;
   logic [QW-1:0] dbl_red_s;
   logic [QW:0]   sum_s;
   logic [QW-1:0] sum_red_s;

   // One interleaved step: r = 2r mod Q, then (+a mod Q) when the scanned bit is set
   always_comb begin
      dbl_s = {r_q, 1'b0};
      if (dbl_s >= Q_X) begin
         dbl_red_s = QW'(dbl_s - Q_X);
      end else begin
         dbl_red_s = QW'(dbl_s);
      end
      if (b_const[cnt_q]) begin
         sum_s = {1'b0, dbl_red_s} + {1'b0, a_q};
      end else begin
         sum_s = {1'b0, dbl_red_s};
      end
      if (sum_s >= Q_X) begin
         sum_red_s = QW'(sum_s - Q_X);
      end else begin
         sum_red_s = QW'(sum_s);
      end
   end

   // Next-state logic: load on start, then step down the bit index to zero
   always_comb begin
      a_d    = a_q;
      r_d    = r_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (busy_q) begin
         r_d = sum_red_s;
         if (cnt_q == CNT_ZRO) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (start) begin
         a_d    = a;
         r_d    = QW'(1'b0);
         cnt_d  = CNT_TOP;
         busy_d = 1'b1;
      end else begin
         busy_d = 1'b0;
      end
   end

   // Multiplier state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= QW'(1'b0);
         r_q    <= QW'(1'b0);
         cnt_q  <= CNT_ZRO;
         busy_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         r_q    <= r_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = busy_q && (cnt_q == CNT_ZRO);
   assign result = sum_red_s;

endmodule

// File: rtl/twiddle_table_gen.sv
// ---------------------------------------------------------------------------
// twiddle_table_gen
// Builds the forward table fwd[bitrev(k)] = psi^k mod Q and the inverse table
// inv[bitrev(k)] = psi^-k mod Q after reset (or on rebuild), using two
// bit-serial modular multipliers, then serves registered single-cycle lookups.
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   rebuild   : pulse; restart table generation (only while ready=1)
//   ready     : tables complete, lookups accepted
//   rd_en     : lookup request
//   rd_inv    : 0 = forward table, 1 = inverse table
//   rd_addr   : table index
//   rd_valid  : rd_data valid this cycle (one cycle after an accepted request)
//   rd_data   : table value
// ---------------------------------------------------------------------------
module twiddle_table_gen
   import ntt_pkg::*;
#(
   parameter int LOG_N   = DEF_LOG_N,
   parameter int QW      = DEF_QW,
   parameter int Q       = DEF_Q,
   parameter int PSI     = DEF_PSI,
   parameter int PSI_INV = DEF_PSI_INV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rebuild,
   output logic             ready,
   input  logic             rd_en,
   input  logic             rd_inv,
   input  logic [LOG_N-1:0] rd_addr,
   output logic             rd_valid,
   output logic [QW-1:0]    rd_data
);

   localparam int               N       = 1 << LOG_N;
   localparam logic [LOG_N-1:0] K_LAST  = LOG_N'(N - 1);
   localparam logic [LOG_N-1:0] K_ONE   = LOG_N'(1'b1);
   localparam logic [LOG_N-1:0] K_ZERO  = LOG_N'(1'b0);
   localparam logic [QW-1:0]    ONE     = QW'(1'b1);
   localparam logic [QW-1:0]    ZERO    = QW'(1'b0);
   localparam logic [QW-1:0]    PSI_C   = QW'(PSI);
   localparam logic [QW-1:0]    PSI_I_C = QW'(PSI_INV);

   tbl_state_e       state_q, state_d;
   logic [LOG_N-1:0] k_q, k_d;
   logic [QW-1:0]    pow_f_q, pow_f_d;
   logic [QW-1:0]    pow_i_q, pow_i_d;
   logic             ready_q, ready_d;
   logic             rd_valid_q, rd_valid_d;
   logic [QW-1:0]    rd_data_q, rd_data_d;

   logic [QW-1:0]    fwd_q [N];
   logic [QW-1:0]    inv_q [N];

   logic             wr_en_s;
   logic [LOG_N-1:0] wr_addr_s;
   logic             mul_start_s;
   logic             mul_busy_f_s, mul_busy_i_s;
   logic             mul_done_f_s, mul_done_i_s;
   logic [QW-1:0]    mul_res_f_s, mul_res_i_s;

   mod_mul_serial #(.QW(QW), .Q(Q)) u_mul_fwd (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .a       (pow_f_q),
      .b_const (PSI_C),
      .busy    (mul_busy_f_s),
      .done    (mul_done_f_s),
      .result  (mul_res_f_s)
   );

   mod_mul_serial #(.QW(QW), .Q(Q)) u_mul_inv (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .a       (pow_i_q),
      .b_const (PSI_I_C),
      .busy    (mul_busy_i_s),
      .done    (mul_done_i_s),
      .result  (mul_res_i_s)
   );

   // Generation FSM next-state: WRITE one entry, MUL QW cycles, repeat until k = N-1
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      pow_f_d     = pow_f_q;
      pow_i_d     = pow_i_q;
      ready_d     = ready_q;
      wr_en_s     = 1'b0;
      mul_start_s = 1'b0;
      wr_addr_s   = LOG_N'(bitrev(32'(k_q), LOG_N));
      case (state_q)
         S_WRITE: begin
            wr_en_s = 1'b1;
            if (k_q == K_LAST) begin
               state_d = S_READY;
               ready_d = 1'b1;
            end else begin
               state_d     = S_MUL;
               mul_start_s = 1'b1;
            end
         end
         S_MUL: begin
            if (mul_done_f_s && mul_done_i_s) begin
               // result is the combinational output of the final step
               pow_f_d = mul_res_f_s;
               pow_i_d = mul_res_i_s;
               k_d     = k_q + K_ONE;
               state_d = S_WRITE;
            end else if (!mul_busy_f_s || !mul_busy_i_s) begin
               // a multiplier dropped out without finishing: redo this step
               state_d = S_WRITE;
            end else begin
               state_d = S_MUL;
            end
         end
         S_READY: begin
            if (rebuild) begin
               state_d = S_WRITE;
               k_d     = K_ZERO;
               pow_f_d = ONE;
               pow_i_d = ONE;
               ready_d = 1'b0;
            end else begin
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = S_WRITE;
            k_d     = K_ZERO;
            pow_f_d = ONE;
            pow_i_d = ONE;
            ready_d = 1'b0;
         end
      endcase
   end

   // Lookup next-state; tables are only read once ready, so a rebuild in the
   // same cycle still returns the old (identical) contents
   always_comb begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      if (rd_en && ready_q) begin
         rd_valid_d = 1'b1;
         if (rd_inv) begin
            rd_data_d = inv_q[rd_addr];
         end else begin
            rd_data_d = fwd_q[rd_addr];
         end
      end else begin
         rd_valid_d = 1'b0;
      end
   end

   // FSM and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_WRITE;
         k_q        <= K_ZERO;
         pow_f_q    <= ONE;
         pow_i_q    <= ONE;
         ready_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= ZERO;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         pow_f_q    <= pow_f_d;
         pow_i_q    <= pow_i_d;
         ready_q    <= ready_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Table write port: contents are undefined until generation reaches them
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         fwd_q[wr_addr_s] <= pow_f_q;
         inv_q[wr_addr_s] <= pow_i_q;
      end
   end

   assign ready    = ready_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_twiddle_table_gen.sv
// ---------------------------------------------------------------------------
// tb_twiddle_table_gen
// Bench for twiddle_table_gen: a default instance (N=16, Q=257) and a small
// instance (N=8, Q=17). Lookup requests push their expected value onto a
// per-instance queue; each cycle the monitor pops and compares on rd_valid.
// ---------------------------------------------------------------------------
module tb_twiddle_table_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rebuild_a, rd_en_a, rd_inv_a, ready_a, rd_valid_a;
   logic [3:0] rd_addr_a;
   logic [8:0] rd_data_a;
   logic       rst_b, rebuild_b, rd_en_b, rd_inv_b, ready_b, rd_valid_b;
   logic [2:0] rd_addr_b;
   logic [4:0] rd_data_b;

   twiddle_table_gen dut_a (
      .clk(clk), .rst(rst_a), .rebuild(rebuild_a), .ready(ready_a),
      .rd_en(rd_en_a), .rd_inv(rd_inv_a), .rd_addr(rd_addr_a),
      .rd_valid(rd_valid_a), .rd_data(rd_data_a)
   );

   twiddle_table_gen #(.LOG_N(3), .QW(5), .Q(17), .PSI(3), .PSI_INV(6)) dut_b (
      .clk(clk), .rst(rst_b), .rebuild(rebuild_b), .ready(ready_b),
      .rd_en(rd_en_b), .rd_inv(rd_inv_b), .rd_addr(rd_addr_b),
      .rd_valid(rd_valid_b), .rd_data(rd_data_b)
   );

   typedef struct {
      int is_inv;
      int addr;
      int exp;
   } req_t;

   req_t q_a[$];
   req_t q_b[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   obs_fwd_a [16];
   int   obs_inv_a [16];
   int   obs_fwd_b [8];
   int   obs_inv_b [8];
   int   fwd_spec_a [16] = '{1, 256, 16, 241, 4, 253, 64, 193, 2, 255, 32, 225, 8, 249, 128, 129};
   int   fwd_spec_b [8]  = '{1, 13, 9, 15, 3, 5, 10, 11};

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int brev(input int v, input int w);
      int r = 0;
      for (int i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   function automatic int powmod(input int b, input int e, input int q);
      longint r = 1;
      for (int i = 0; i < e; i++) r = (r * b) % q;
      return int'(r);
   endfunction

   // Advance one clock, sample 1 time unit after the edge, run both scoreboards
   task automatic step();
      req_t r;
      @(posedge clk);
      #1;
      check_eq("rd_valid_a", int'(rd_valid_a), (q_a.size() != 0) ? 1 : 0);
      if (rd_valid_a && q_a.size() != 0) begin
         r = q_a.pop_front();
         check_eq(r.is_inv ? "inv_data_a" : "fwd_data_a", int'(rd_data_a), r.exp);
         if (r.is_inv != 0) obs_inv_a[r.addr] = int'(rd_data_a);
         else               obs_fwd_a[r.addr] = int'(rd_data_a);
      end else if (q_a.size() != 0) begin
         r = q_a.pop_front();
      end
      check_eq("rd_valid_b", int'(rd_valid_b), (q_b.size() != 0) ? 1 : 0);
      if (rd_valid_b && q_b.size() != 0) begin
         r = q_b.pop_front();
         check_eq(r.is_inv ? "inv_data_b" : "fwd_data_b", int'(rd_data_b), r.exp);
         if (r.is_inv != 0) obs_inv_b[r.addr] = int'(rd_data_b);
         else               obs_fwd_b[r.addr] = int'(rd_data_b);
      end else if (q_b.size() != 0) begin
         r = q_b.pop_front();
      end
   endtask

   // Count edges until ready (bounded); optionally poke rd_en during generation
   task automatic wait_ready(input int which, input string tag, input int exp_n, input bit poke);
      int n = 0;
      while (((which == 0) ? ready_a : ready_b) == 1'b0 && n < 1000) begin
         if (poke && (n == 20 || n == 21 || n == 100)) begin
            rd_en_a = 1'b1; rd_addr_a = 4'd5; rd_inv_a = 1'b0;
         end else begin
            rd_en_a = 1'b0;
         end
         step();
         n++;
      end
      rd_en_a = 1'b0;
      check_eq(tag, n, exp_n);
   endtask

   task automatic req_a(input int inv, input int addr, input int exp);
      req_t r;
      rd_en_a = 1'b1; rd_inv_a = inv[0]; rd_addr_a = 4'(addr);
      r.is_inv = inv; r.addr = addr; r.exp = exp;
      q_a.push_back(r);
   endtask

   task automatic req_b(input int inv, input int addr, input int exp);
      req_t r;
      rd_en_b = 1'b1; rd_inv_b = inv[0]; rd_addr_b = 3'(addr);
      r.is_inv = inv; r.addr = addr; r.exp = exp;
      q_b.push_back(r);
   endtask

   initial begin
      rst_a = 1'b1; rebuild_a = 1'b0; rd_en_a = 1'b0; rd_inv_a = 1'b0; rd_addr_a = 4'd0;
      rst_b = 1'b1; rebuild_b = 1'b0; rd_en_b = 1'b0; rd_inv_b = 1'b0; rd_addr_b = 3'd0;
      repeat (3) step();
      check_eq("reset_ready_a", int'(ready_a), 0);
      check_eq("reset_data_a", int'(rd_data_a), 0);
      check_eq("reset_ready_b", int'(ready_b), 0);

      // default generation latency, with stray lookups during generation
      rst_a = 1'b0;
      wait_ready(0, "gen_latency_a", 151, 1'b1);

      // forward table, spaced requests
      for (int i = 0; i < 16; i++) begin
         req_a(0, i, fwd_spec_a[i]);
         step();
         rd_en_a = 1'b0;
         step();
      end

      // inverse table, back-to-back requests
      for (int i = 0; i < 16; i++) begin
         req_a(1, i, powmod(129, brev(i, 4), 257));
         step();
      end
      rd_en_a = 1'b0;
      check_eq("inv_addr0", obs_inv_a[0], 1);
      check_eq("inv_addr1", obs_inv_a[1], 256);
      check_eq("inv_addr8", obs_inv_a[8], 129);
      for (int i = 0; i < 16; i++) check_eq("fwd_x_inv_a", (obs_fwd_a[i] * obs_inv_a[i]) % 257, 1);

      // rebuild together with a read of address 3
      rebuild_a = 1'b1;
      req_a(0, 3, 241);
      step();
      rebuild_a = 1'b0; rd_en_a = 1'b0;
      check_eq("rebuild_ready_drop", int'(ready_a), 0);
      wait_ready(0, "rebuild_latency_a", 151, 1'b0);
      for (int i = 0; i < 16; i++) begin
         req_a(0, i, fwd_spec_a[i]);
         step();
      end
      rd_en_a = 1'b0;

      // reset in the middle of generation
      rebuild_a = 1'b1;
      step();
      rebuild_a = 1'b0;
      repeat (70) step();
      rst_a = 1'b1;
      #1;
      check_eq("midgen_rst_ready", int'(ready_a), 0);
      repeat (2) step();
      check_eq("midgen_rst_ready_held", int'(ready_a), 0);
      rst_a = 1'b0;
      wait_ready(0, "regen_latency_a", 151, 1'b0);

      // reset while a lookup result is on the outputs
      req_a(1, 8, 129);
      @(posedge clk);
      #1;
      rd_en_a = 1'b0;
      check_eq("pre_rst_valid", int'(rd_valid_a), 1);
      rst_a = 1'b1;
      #1;
      check_eq("rst_drops_valid", int'(rd_valid_a), 0);
      q_a.delete();
      step();
      rst_a = 1'b0;
      wait_ready(0, "post_rst_latency_a", 151, 1'b0);
      for (int i = 0; i < 16; i += 5) begin
         req_a(0, i, fwd_spec_a[i]);
         step();
      end
      rd_en_a = 1'b0;

      // second configuration: N=8, Q=17, psi=3, psi^-1=6
      rst_b = 1'b0;
      wait_ready(1, "gen_latency_b", 8 + 7 * 5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         req_b(0, i, fwd_spec_b[i]);
         step();
      end
      for (int i = 0; i < 8; i++) begin
         req_b(1, i, powmod(6, brev(i, 3), 17));
         step();
      end
      rd_en_b = 1'b0;
      step();
      for (int i = 0; i < 8; i++) check_eq("fwd_x_inv_b", (obs_fwd_b[i] * obs_inv_b[i]) % 17, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
